// File: rtl/regfile_wr_arbiter_if.sv
// Bundles both requester handshakes, the register-file write port and the debug
// wait counter. The master side is the requesters; the slave side is the arbiter.
interface regfile_wr_arbiter_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            a_valid;
  logic [AW-1:0]   a_addr;
  logic [XLEN-1:0] a_data;
  logic            a_ready;
  logic            b_valid;
  logic [AW-1:0]   b_addr;
  logic [XLEN-1:0] b_data;
  logic            b_ready;
  logic            we3;
  logic [AW-1:0]   ad3;
  logic [XLEN-1:0] wd3;
  logic [3:0]      b_wait_cnt;

  modport master (
    output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    input  a_ready, b_ready, we3, ad3, wd3, b_wait_cnt
  );

  modport slave (
    input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
    output a_ready, b_ready, we3, ad3, wd3, b_wait_cnt
  );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Two-requester arbiter for the single register-file write port. Grants are
// combinational; the write port is registered one cycle after the handshake.
module regfile_wr_arbiter #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int RR_MODE  = 0,
  parameter int MAX_WAIT = 4
) (
  input logic                clk,
  input logic                rst,
  regfile_wr_arbiter_if.slave bus
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic            contested;
  logic            b_wins;
  logic            grant_a;
  logic            grant_b;
  logic            xfer;
  logic [AW-1:0]   sel_addr;
  logic [XLEN-1:0] sel_data;

  logic            last_b_p0;
  logic [3:0]      wait_cnt_p0;
  logic            we3_p0;
  logic [AW-1:0]   ad3_p0;
  logic [XLEN-1:0] wd3_p0;

  // Grant decision: only a contested cycle consults the arbitration state
  always_comb begin
    contested = bus.a_valid && bus.b_valid;
    if (RR_MODE != 0) b_wins = !last_b_p0;
    else              b_wins = (wait_cnt_p0 == WAIT_LIMIT);
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!rst) begin
      if (contested) begin
        grant_a = !b_wins;
        grant_b = b_wins;
      end else begin
        grant_a = bus.a_valid;
        grant_b = bus.b_valid;
      end
    end
    xfer     = grant_a || grant_b;
    sel_addr = grant_b ? bus.b_addr : bus.a_addr;
    sel_data = grant_b ? bus.b_data : bus.a_data;
  end

  // Stage p0: registered write port plus arbitration state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we3_p0      <= 1'b0;
      ad3_p0      <= '0;
      wd3_p0      <= '0;
      last_b_p0   <= 1'b1;
      wait_cnt_p0 <= 4'd0;
    end else begin
      // x0 writes still complete their handshake but never reach the port
      we3_p0 <= xfer && (sel_addr != '0);
      if (xfer) begin
        ad3_p0    <= sel_addr;
        wd3_p0    <= sel_data;
        last_b_p0 <= grant_b;
      end
      if (RR_MODE == 0) begin
        if (grant_b)
          wait_cnt_p0 <= 4'd0;
        else if (contested && grant_a && wait_cnt_p0 != WAIT_LIMIT)
          wait_cnt_p0 <= wait_cnt_p0 + 4'd1;
      end
    end
  end

  assign bus.a_ready    = grant_a;
  assign bus.b_ready    = grant_b;
  assign bus.we3        = we3_p0;
  assign bus.ad3        = ad3_p0;
  assign bus.wd3        = wd3_p0;
  assign bus.b_wait_cnt = wait_cnt_p0;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: one fixed-priority and one round-robin instance,
// driven by a directed vector table, a reset sequence and randomized traffic.
module tb_regfile_wr_arbiter;
  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int MAX_WAIT = 4;
  localparam int NVEC     = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wr_arbiter_if #(.XLEN(XLEN), .AW(AW)) bus_fp ();
  regfile_wr_arbiter_if #(.XLEN(XLEN), .AW(AW)) bus_rr ();

  regfile_wr_arbiter #(.XLEN(XLEN), .AW(AW), .RR_MODE(0), .MAX_WAIT(MAX_WAIT))
    dut_fp (.clk(clk), .rst(rst), .bus(bus_fp));
  regfile_wr_arbiter #(.XLEN(XLEN), .AW(AW), .RR_MODE(1), .MAX_WAIT(MAX_WAIT))
    dut_rr (.clk(clk), .rst(rst), .bus(bus_rr));

  // Index 0 = fixed-priority instance, index 1 = round-robin instance
  logic            av[2], bv[2];
  logic [AW-1:0]   aa[2], ba[2];
  logic [XLEN-1:0] adat[2], bdat[2];
  logic            ar[2], br[2], we[2];
  logic [AW-1:0]   ad3[2];
  logic [XLEN-1:0] wd3[2];
  logic [3:0]      cnt[2];

  assign bus_fp.a_valid = av[0];   assign bus_rr.a_valid = av[1];
  assign bus_fp.a_addr  = aa[0];   assign bus_rr.a_addr  = aa[1];
  assign bus_fp.a_data  = adat[0]; assign bus_rr.a_data  = adat[1];
  assign bus_fp.b_valid = bv[0];   assign bus_rr.b_valid = bv[1];
  assign bus_fp.b_addr  = ba[0];   assign bus_rr.b_addr  = ba[1];
  assign bus_fp.b_data  = bdat[0]; assign bus_rr.b_data  = bdat[1];
  assign ar[0]  = bus_fp.a_ready;    assign ar[1]  = bus_rr.a_ready;
  assign br[0]  = bus_fp.b_ready;    assign br[1]  = bus_rr.b_ready;
  assign we[0]  = bus_fp.we3;        assign we[1]  = bus_rr.we3;
  assign ad3[0] = bus_fp.ad3;        assign ad3[1] = bus_rr.ad3;
  assign wd3[0] = bus_fp.wd3;        assign wd3[1] = bus_rr.wd3;
  assign cnt[0] = bus_fp.b_wait_cnt; assign cnt[1] = bus_rr.b_wait_cnt;

  typedef struct {
    logic            av;
    logic [AW-1:0]   aa;
    logic [XLEN-1:0] ad;
    logic            bv;
    logic [AW-1:0]   ba;
    logic [XLEN-1:0] bd;
    logic            fp_ga, fp_gb;
    int              fp_cnt;
    logic            rr_ga, rr_gb;
  } vec_t;

  vec_t tbl[NVEC];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int m, input logic v_a, input logic [AW-1:0] a_a,
                       input logic [XLEN-1:0] d_a, input logic v_b,
                       input logic [AW-1:0] a_b, input logic [XLEN-1:0] d_b);
    av[m] = v_a; aa[m] = a_a; adat[m] = d_a;
    bv[m] = v_b; ba[m] = a_b; bdat[m] = d_b;
  endtask

  function automatic vec_t mk(input logic v_a, input logic [AW-1:0] a_a,
                              input logic [XLEN-1:0] d_a, input logic v_b,
                              input logic [AW-1:0] a_b, input logic [XLEN-1:0] d_b,
                              input logic fa, input logic fb, input int fc,
                              input logic ra, input logic rb);
    vec_t v;
    v.av = v_a; v.aa = a_a; v.ad = d_a; v.bv = v_b; v.ba = a_b; v.bd = d_b;
    v.fp_ga = fa; v.fp_gb = fb; v.fp_cnt = fc; v.rr_ga = ra; v.rr_gb = rb;
    return v;
  endfunction

  task automatic chk_all_zero(input string tag);
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s m%0d we3", tag, m), we[m], 0);
      chk($sformatf("%s m%0d ad3", tag, m), ad3[m], 0);
      chk($sformatf("%s m%0d wd3", tag, m), wd3[m], 0);
      chk($sformatf("%s m%0d a_ready", tag, m), ar[m], 0);
      chk($sformatf("%s m%0d b_ready", tag, m), br[m], 0);
      chk($sformatf("%s m%0d b_wait_cnt", tag, m), cnt[m], 0);
    end
  endtask

  // Behavioural model state: who won last, and B's run of contested losses
  logic model_last_b[2];
  int   model_loss[2];
  logic exp_ga[2], exp_gb[2], exp_we[2];
  logic [AW-1:0]   exp_addr[2];
  logic [XLEN-1:0] exp_data[2];

  initial begin
    for (int m = 0; m < 2; m++) drive(m, 1'b1, 5'd6, 32'h66, 1'b1, 5'd9, 32'h99);

    // Reset held from time 0: outputs quiet even with both requesters valid
    #2;
    chk_all_zero("reset_hold");
    #10 rst = 1'b0;
    @(posedge clk); #1;
    chk("pre_async fp we3", we[0], 1);
    chk("pre_async fp ad3", ad3[0], 6);
    chk("pre_async fp cnt", cnt[0], 1);
    chk("pre_async rr ad3", ad3[1], 6);
    // Asynchronous reset in mid-cycle must clear everything at once
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    for (int m = 0; m < 2; m++) drive(m, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Directed vectors; expected b_wait_cnt is the value after the edge
    tbl[0] = mk(1, 5, 32'hDEADBEEF, 0, 0, 32'h0,    1, 0, 0, 1, 0);
    tbl[1] = mk(0, 0, 32'h0, 1, 31, 32'h1234,      0, 1, 0, 0, 1);
    tbl[2] = mk(0, 0, 32'h0, 0, 0, 32'h0,          0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      int  c;
      logic fb;
      fb = (i == 4) || (i == 9);
      c  = (i < 4) ? i + 1 : (i == 4) ? 0 : (i < 9) ? i - 4 : 0;
      tbl[3 + i] = mk(1, 3, 32'hAAAA0003, 1, 7, 32'hB0B0B0B0,
                      !fb, fb, c, (i % 2) == 0, (i % 2) == 1);
    end
    tbl[13] = mk(1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,  1, 0, 0, 1, 0);
    tbl[14] = mk(1, 3, 32'hAAAA0003, 1, 0, 32'h55, 1, 0, 1, 0, 1);
    tbl[15] = mk(0, 0, 32'h0, 1, 0, 32'h55,        0, 1, 0, 0, 1);
    tbl[16] = mk(1, 4, 32'h44, 1, 9, 32'h99,       1, 0, 1, 1, 0);
    tbl[17] = mk(1, 4, 32'h44, 1, 9, 32'h99,       1, 0, 2, 0, 1);
    tbl[18] = mk(0, 0, 32'h0, 1, 9, 32'h99,        0, 1, 0, 0, 1);
    tbl[19] = mk(0, 0, 32'h0, 0, 0, 32'h0,         0, 0, 0, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      logic ga[2], gb[2];
      logic [AW-1:0] wa;
      logic [XLEN-1:0] wdv;
      for (int m = 0; m < 2; m++)
        drive(m, tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].bv, tbl[i].ba, tbl[i].bd);
      ga[0] = tbl[i].fp_ga; gb[0] = tbl[i].fp_gb;
      ga[1] = tbl[i].rr_ga; gb[1] = tbl[i].rr_gb;
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("v%0d m%0d a_ready", i, m), ar[m], ga[m]);
        chk($sformatf("v%0d m%0d b_ready", i, m), br[m], gb[m]);
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d fp b_wait_cnt", i), cnt[0], tbl[i].fp_cnt);
      chk($sformatf("v%0d rr b_wait_cnt", i), cnt[1], 0);
      for (int m = 0; m < 2; m++) begin
        wa  = gb[m] ? tbl[i].ba : tbl[i].aa;
        wdv = gb[m] ? tbl[i].bd : tbl[i].ad;
        chk($sformatf("v%0d m%0d we3", i, m), we[m], (ga[m] || gb[m]) && wa != 0);
        if ((ga[m] || gb[m]) && wa != 0) begin
          chk($sformatf("v%0d m%0d ad3", i, m), ad3[m], wa);
          chk($sformatf("v%0d m%0d wd3", i, m), wd3[m], wdv);
        end
      end
    end

    // Randomized traffic against the behavioural model, fresh from reset
    #2 rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      drive(m, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      model_last_b[m] = 1'b1;
      model_loss[m]   = 0;
      exp_ga[m] = 1'b0;
      exp_gb[m] = 1'b0;
    end
    @(posedge clk); #1;
    rst = 1'b0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int m = 0; m < 2; m++) begin
        // A requester keeps its request until it is accepted
        if (!(av[m] && !exp_ga[m])) begin
          av[m]   = ($urandom_range(0, 99) < 65);
          aa[m]   = ($urandom_range(0, 5) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
          adat[m] = $urandom;
        end
        if (!(bv[m] && !exp_gb[m])) begin
          bv[m]   = ($urandom_range(0, 99) < 65);
          ba[m]   = ($urandom_range(0, 5) == 0) ? 5'd0 : AW'($urandom_range(1, 31));
          bdat[m] = $urandom;
        end
      end
      @(negedge clk);
      for (int m = 0; m < 2; m++) begin
        logic both, b_first;
        both = av[m] && bv[m];
        if (m == 1) b_first = !model_last_b[m];
        else        b_first = (model_loss[m] == MAX_WAIT);
        exp_ga[m]   = av[m] && !(both && b_first);
        exp_gb[m]   = bv[m] && !exp_ga[m];
        exp_addr[m] = exp_gb[m] ? ba[m] : aa[m];
        exp_data[m] = exp_gb[m] ? bdat[m] : adat[m];
        exp_we[m]   = (exp_ga[m] || exp_gb[m]) && exp_addr[m] != 0;
        chk($sformatf("rnd%0d m%0d a_ready", cyc, m), ar[m], exp_ga[m]);
        chk($sformatf("rnd%0d m%0d b_ready", cyc, m), br[m], exp_gb[m]);
        chk($sformatf("rnd%0d m%0d b_wait_cnt", cyc, m), cnt[m], model_loss[m]);
        if (exp_ga[m] || exp_gb[m]) model_last_b[m] = exp_gb[m];
        if (m == 0) begin
          if (exp_gb[m])                              model_loss[m] = 0;
          else if (both && model_loss[m] < MAX_WAIT)  model_loss[m]++;
        end
      end
      @(posedge clk); #1;
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("rnd%0d m%0d we3", cyc, m), we[m], exp_we[m]);
        if (exp_we[m]) begin
          chk($sformatf("rnd%0d m%0d ad3", cyc, m), ad3[m], exp_addr[m]);
          chk($sformatf("rnd%0d m%0d wd3", cyc, m), wd3[m], exp_data[m]);
        end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
